cmd_sequencer: RTL and testbench
================================

# cmd_sequencer

Hardware command sequencer that plays a stored list of 16-bit Knight commands into `RemoteComm` and checks each acknowledge. It sits between a host/loader and `RemoteComm`, replacing hand-written per-command send/wait/check bench code. Commands are issued one at a time; each response byte is checked; the block stops with a coded error on a NAK, a timeout or an abort. The list is retained after a run so it can be replayed.

## Interface
- `DEPTH`, 16: number of command slots (power of two, ≥2).
- `TIMEOUT_CLKS`, 50_000_000: maximum clocks allowed in each wait state before a timeout error.
- `ACK_VAL`, 8'hA5: response byte counted as a positive acknowledge.
- `MAX_RETRY`, 2: number of re-issues after a timeout (used only with `CMD_SEQ_RETRY_EN`).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `load` in 1: write `load_cmd` to slot `count`.
- `load_cmd` in 16: command to store.
- `clear` in 1: empty the list (`count`←0).
- `start` in 1: run the list from slot 0.
- `abort` in 1: stop the current run.
- `cmd` out 16: command presented to `RemoteComm`.
- `snd_cmd` out 1: one-cycle send strobe to `RemoteComm`.
- `cmd_snt` in 1: `RemoteComm` has finished transmitting.
- `resp_rdy` in 1: response byte valid (one-cycle pulse).
- `resp` in 8: response byte.
- `count` out $clog2(DEPTH)+1: number of stored commands.
- `full` out 1: `count==DEPTH`.
- `ovf` out 1: sticky flag; set by a load while full; cleared by `clear`.
- `busy` out 1: run in progress.
- `done` out 1: last run completed with no error; held until the next `start` or `clear`.
- `err` out 1: last run ended in error; held until the next `start` or `clear`.
- `err_code` out 2: 0 none, 1 NAK, 2 timeout, 3 abort.
- `idx` out $clog2(DEPTH): slot being issued, or the slot that failed.

## Operation
States: IDLE, ISSUE, WAIT_SNT, WAIT_RESP, FINISH.
- **IDLE**
  - `load` is accepted only in IDLE and when not full; the store goes to `mem[count]` and `count` increments.
  - A load while full is dropped and sets `ovf`.
  - `clear` takes priority over `load` and `start` in the same cycle.
  - `start` with `count==0`: go to FINISH, `done`=1.
  - `start` otherwise: `idx`←0, clear `done`/`err`, go to ISSUE.
- **ISSUE**
  - `cmd`←`mem[idx]`, pulse `snd_cmd` for one cycle, clear the timer, go to WAIT_SNT.
- **WAIT_SNT**
  - On `cmd_snt`: clear the timer and go to WAIT_RESP.
  - On timer `==TIMEOUT_CLKS-1`: timeout.
- **WAIT_RESP**
  - On `resp_rdy` with `resp==ACK_VAL`:
    - if `idx==count-1`, go to FINISH with `done`=1;
    - otherwise `idx++` and go to ISSUE.
  - On `resp_rdy` with any other value: go to FINISH, `err`=1, code 1.
  - On timeout: go to FINISH, `err`=1, code 2.
  - If `resp_rdy` arrives in the same cycle as the timeout, the response wins.
- **Abort**
  - `abort` in ISSUE, WAIT_SNT or WAIT_RESP: go to FINISH, `err`=1, code 3.
  - `abort` has priority over `resp_rdy` and over timeout in the same cycle.
  - `abort` in IDLE or FINISH is ignored.
- **FINISH**
  - Returns to IDLE next cycle; `done`/`err`/`err_code`/`idx` hold.
- `start`, `load` and `clear` outside IDLE are ignored; they do not set `ovf`.
- `busy` is 1 in ISSUE, WAIT_SNT and WAIT_RESP.
- Timer width is $clog2(TIMEOUT_CLKS). It saturates and does not wrap.

## Timing
- Every output is registered.
- Reset values:
  - `cmd`=16'h0000; `snd_cmd`, `ovf`, `busy`, `done`, `err`=0; `err_code`=0; `idx`=0; `count`=0.
  - State is IDLE; memory contents are don't-care.
- Latency:
  - `start` → `snd_cmd` high: 2 cycles.
  - ACK `resp_rdy` → next `snd_cmd`: 2 cycles.
  - Final ACK → `done`: 1 cycle.
- `cmd` is stable from the `snd_cmd` cycle until the next ISSUE.
- `rst_n` low mid-run returns everything to reset values at the next edge. The list is lost because `count`=0.

## Configuration
- `CMD_SEQ_RETRY_EN` defined:
  - A timeout re-enters ISSUE for the same `idx`, up to `MAX_RETRY` times per command; the retry counter is cleared on each ACK.
  - Timeout error code 2 is raised only after the retries are exhausted.
  - A NAK is never retried.
- `CMD_SEQ_RETRY_EN` undefined: the first timeout is final. There is no retry counter logic, and `MAX_RETRY` is unused.

## Structure
- Package `cmd_seq_pkg` holds:
  - the `state_t` enum;
  - the `err_code_t` enum (`ERR_NONE`, `ERR_NAK`, `ERR_TMO`, `ERR_ABORT`);
  - the default `ACK_VAL`;
  - the shared command constants (`CAL_GYRO`, move opcodes) used by the benches.
- Sub-module `cmd_list_mem`: a DEPTH×16 register array with a write port (`we`, `waddr`, `wdata`) and a combinational read port, no reset.

## Test plan
- **Normal run:** load 16'h53F4, 16'h47F1, 16'h5BF4; `start`; a `RemoteComm` model returns 8'hA5 each time → exactly 3 `snd_cmd` pulses, `cmd` sequence matches, `done`=1, `err`=0, `idx`=2.
- **NAK:** load 3 commands; 2nd response = 8'h5A → `err`=1, `err_code`=1, `idx`=1, no third `snd_cmd`.
- **Timeout:** `TIMEOUT_CLKS`=1000; model never asserts `resp_rdy`.
  - Without the macro → `err_code`=2 at 1000 clocks after `cmd_snt`.
  - With the macro and `MAX_RETRY`=2 → 3 `snd_cmd` pulses, then `err_code`=2.
- **Full/ovf:** `DEPTH`=4; load 5 commands → `count`=4, `full`=1, `ovf`=1; `clear` → `count`=0, `ovf`=0.
- **Abort:** `abort` asserted together with an ACK `resp_rdy` in WAIT_RESP → `err_code`=3, `busy`=0 in 2 cycles; a subsequent `start` replays from `idx`=0.
- **Empty/reset:** `start` with `count`=0 → `done`=1 next cycle, no `snd_cmd`; `rst_n` low mid-WAIT_RESP → all outputs at reset values.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command sequencer: FSM states, error codes,
// the default acknowledge byte and Knight command encodings used by the benches.
package cmd_seq_pkg;

    localparam int CMD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_SNT,
        S_WAIT_RESP,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_NAK   = 2'd1,
        ERR_TMO   = 2'd2,
        ERR_ABORT = 2'd3
    } err_code_t;

    localparam logic [7:0] ACK_VAL_DEFAULT = 8'hA5;

    // Knight opcodes live in the top nibble of a command word.
    localparam logic [3:0]       MOVE_OPC         = 4'h4;
    localparam logic [3:0]       MOVE_FANFARE_OPC = 4'h5;
    localparam logic [CMD_W-1:0] CAL_GYRO         = 16'h2000;

endpackage

// File: rtl/cmd_list_mem.sv
// Command list storage: DEPTH x 16 register array, one write port,
// combinational read port, no reset.
module cmd_list_mem
    import cmd_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [CMD_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [CMD_W-1:0] rdata
);

    logic [CMD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cmd_sequencer.sv
// Plays a stored list of Knight commands into RemoteComm and checks each ACK.
// Optional macro CMD_SEQ_RETRY_EN: re-issue a timed-out command up to MAX_RETRY times.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int          DEPTH        = 16,
    parameter int          TIMEOUT_CLKS = 50_000_000,
    parameter logic [7:0]  ACK_VAL      = ACK_VAL_DEFAULT,
    parameter int          MAX_RETRY    = 2,
    localparam int         AW           = $clog2(DEPTH),
    localparam int         CW           = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CMD_W-1:0] load_cmd,
    input  logic             clear,
    input  logic             start,
    input  logic             abort,
    output logic [CMD_W-1:0] cmd,
    output logic             snd_cmd,
    input  logic             cmd_snt,
    input  logic             resp_rdy,
    input  logic [7:0]       resp,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [AW-1:0]    idx
);

    localparam int          TMR_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CLKS - 1);

    state_t           state, state_nxt;
    logic [AW-1:0]    idx_nxt;
    logic [CW-1:0]    count_nxt;
    logic [CMD_W-1:0] cmd_nxt, rdata;
    logic             snd_nxt, ovf_nxt, done_nxt, err_nxt, we, tmr_clr, tmo;
    err_code_t        code_nxt;
    logic [TMR_W-1:0] tmr;

`ifdef CMD_SEQ_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTY_W-1:0] rty;
    logic             rty_inc, rty_clr;
`endif

    cmd_list_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (count[AW-1:0]),
        .wdata (load_cmd),
        .raddr (idx),
        .rdata (rdata)
    );

    assign tmo = (tmr == TMO_LAST);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        count_nxt = count;
        cmd_nxt   = cmd;
        snd_nxt   = 1'b0;
        ovf_nxt   = ovf;
        done_nxt  = done;
        err_nxt   = err;
        code_nxt  = err_code_t'(err_code);
        we        = 1'b0;
        tmr_clr   = 1'b0;
`ifdef CMD_SEQ_RETRY_EN
        rty_inc   = 1'b0;
        rty_clr   = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (clear) begin
                    count_nxt = '0;
                    ovf_nxt   = 1'b0;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    code_nxt  = ERR_NONE;
                end else begin
                    if (load) begin
                        if (full) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            we        = 1'b1;
                            count_nxt = count + CW'(1);
                        end
                    end
                    if (start) begin
                        done_nxt = 1'b0;
                        err_nxt  = 1'b0;
                        code_nxt = ERR_NONE;
                        if (count == '0) begin
                            done_nxt  = 1'b1;
                            state_nxt = S_FINISH;
                        end else begin
                            idx_nxt   = '0;
                            state_nxt = S_ISSUE;
`ifdef CMD_SEQ_RETRY_EN
                            rty_clr   = 1'b1;
`endif
                        end
                    end
                end
            end
            S_ISSUE, S_WAIT_SNT, S_WAIT_RESP: begin
                // Abort outranks any response or timeout seen in the same cycle.
                if (abort) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_ABORT;
                    state_nxt = S_FINISH;
                end else if (state == S_ISSUE) begin
                    cmd_nxt   = rdata;
                    snd_nxt   = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nxt = S_WAIT_SNT;
                end else if (state == S_WAIT_SNT && cmd_snt) begin
                    tmr_clr   = 1'b1;
                    state_nxt = S_WAIT_RESP;
                end else if (state == S_WAIT_RESP && resp_rdy) begin
                    if (resp == ACK_VAL) begin
`ifdef CMD_SEQ_RETRY_EN
                        rty_clr = 1'b1;
`endif
                        if (CW'(idx) == count - CW'(1)) begin
                            done_nxt  = 1'b1;
                            state_nxt = S_FINISH;
                        end else begin
                            idx_nxt   = idx + AW'(1);
                            state_nxt = S_ISSUE;
                        end
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_NAK;
                        state_nxt = S_FINISH;
                    end
                end else if (state != S_ISSUE && tmo) begin
`ifdef CMD_SEQ_RETRY_EN
                    if (rty < RTY_W'(MAX_RETRY)) begin
                        rty_inc   = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_TMO;
                        state_nxt = S_FINISH;
                    end
`else
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_TMO;
                    state_nxt = S_FINISH;
`endif
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs: every port reflects the state the FSM is entering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            count    <= '0;
            cmd      <= '0;
            snd_cmd  <= 1'b0;
            full     <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            count    <= count_nxt;
            cmd      <= cmd_nxt;
            snd_cmd  <= snd_nxt;
            full     <= (count_nxt == CW'(DEPTH));
            ovf      <= ovf_nxt;
            busy     <= (state_nxt == S_ISSUE) || (state_nxt == S_WAIT_SNT) ||
                        (state_nxt == S_WAIT_RESP);
            done     <= done_nxt;
            err      <= err_nxt;
            err_code <= code_nxt;
        end
    end

    // Wait timer saturates at the timeout value instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n || tmr_clr || (state != S_WAIT_SNT && state != S_WAIT_RESP)) begin
            tmr <= '0;
        end else if (!tmo) begin
            tmr <= tmr + TMR_W'(1);
        end
    end

`ifdef CMD_SEQ_RETRY_EN
    always_ff @(posedge clk) begin
        if (!rst_n || rty_clr) begin
            rty <= '0;
        end else if (rty_inc) begin
            rty <= rty + RTY_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer with a RemoteComm response model.
// Honours CMD_SEQ_RETRY_EN for the timeout expectations.
module tb_cmd_sequencer;
    import cmd_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 1000;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
`ifdef CMD_SEQ_RETRY_EN
    localparam int TMO_ISSUES = 3;
`else
    localparam int TMO_ISSUES = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n, load, clear, start, abort, cmd_snt, resp_rdy;
    logic [15:0]   load_cmd, cmd;
    logic [7:0]    resp;
    logic          snd_cmd, full, ovf, busy, done, err;
    logic [CW-1:0] count;
    logic [1:0]    err_code;
    logic [AW-1:0] idx;

    int          checks = 0;
    int          errors = 0;
    int          n_snd  = 0;
    int          snd0;
    int          resp_mode;
    logic [7:0]  resp_val [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] prog [3];

    always #5 clk = ~clk;

    cmd_sequencer #(
        .DEPTH(DEPTH), .TIMEOUT_CLKS(TMO), .ACK_VAL(8'hA5), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_cmd(load_cmd), .clear(clear),
        .start(start), .abort(abort), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
        .resp_rdy(resp_rdy), .resp(resp), .count(count), .full(full), .ovf(ovf),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .idx(idx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RemoteComm model: pops the scoreboard on each send strobe, then acknowledges.
    initial begin
        cmd_snt = 1'b0; resp_rdy = 1'b0; resp = 8'h00; abort = 1'b0;
        forever begin
            @(posedge clk); #1;
            cmd_snt = 1'b0; resp_rdy = 1'b0; abort = 1'b0;
            if (snd_cmd) begin
                n_snd++;
                if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else chk("cmd", {16'h0, cmd}, {16'h0, exp_q.pop_front()});
                @(posedge clk); #1;
                cmd_snt = 1'b1;
                @(posedge clk); #1;
                cmd_snt = 1'b0;
                @(posedge clk); #1;
                if (resp_mode != 0) begin
                    resp_rdy = 1'b1;
                    resp     = resp_val[idx];
                    abort    = (resp_mode == 2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_cmd = v; tick(); load = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin tick(); n++; end
        if (busy) chk("wait_idle_bound", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_snd();
        int n = 0;
        while (!snd_cmd && n < 100) begin tick(); n++; end
        if (!snd_cmd) chk("wait_snd_bound", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd"}, {16'h0, cmd}, 32'h0);
        chk({tag, "_snd"}, {31'h0, snd_cmd}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_err"}, {31'h0, err}, 32'h0);
        chk({tag, "_code"}, {30'h0, err_code}, 32'h0);
        chk({tag, "_idx"}, 32'(idx), 32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_ovf"}, {31'h0, ovf}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; clear = 1'b0; start = 1'b0; load_cmd = 16'h0;
        resp_mode = 1;
        for (int i = 0; i < DEPTH; i++) resp_val[i] = 8'hA5;
        prog[0] = {MOVE_FANFARE_OPC, 12'h3F4};
        prog[1] = {MOVE_OPC, 12'h7F1};
        prog[2] = {MOVE_FANFARE_OPC, 12'hBF4};
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Normal run
        for (int i = 0; i < 3; i++) begin do_load(prog[i]); exp_q.push_back(prog[i]); end
        chk("count3", 32'(count), 32'd3);
        snd0 = n_snd;
        do_start();
        chk("busy_run", {31'h0, busy}, 32'd1);
        chk("snd_not_yet", {31'h0, snd_cmd}, 32'd0);
        tick();
        chk("start_to_snd", {31'h0, snd_cmd}, 32'd1);
        wait_idle();
        chk("norm_done", {31'h0, done}, 32'd1);
        chk("norm_err", {31'h0, err}, 32'd0);
        chk("norm_idx", 32'(idx), 32'd2);
        chk("norm_nsnd", 32'(n_snd - snd0), 32'd3);
        chk("norm_q", 32'(exp_q.size()), 32'd0);

        // NAK on the second response
        do_clear();
        for (int i = 0; i < 3; i++) do_load(prog[2 - i]);
        exp_q.push_back(prog[2]); exp_q.push_back(prog[1]);
        resp_val[1] = 8'h5A;
        snd0 = n_snd;
        do_start();
        wait_idle();
        repeat (10) tick();
        chk("nak_err", {31'h0, err}, 32'd1);
        chk("nak_done", {31'h0, done}, 32'd0);
        chk("nak_code", {30'h0, err_code}, 32'd1);
        chk("nak_idx", 32'(idx), 32'd1);
        chk("nak_nsnd", 32'(n_snd - snd0), 32'd2);
        resp_val[1] = 8'hA5;

        // Timeout: no response ever arrives
        do_clear();
        do_load(CAL_GYRO);
        for (int i = 0; i < TMO_ISSUES; i++) exp_q.push_back(CAL_GYRO);
        resp_mode = 0;
        snd0 = n_snd;
        do_start();
        wait_snd();
        begin
            int n = 0;
            while (!err && n < 5000) begin tick(); n++; end
`ifndef CMD_SEQ_RETRY_EN
            chk("tmo_latency", 32'(n), 32'd1002);
`endif
        end
        tick(); tick();
        chk("tmo_err", {31'h0, err}, 32'd1);
        chk("tmo_code", {30'h0, err_code}, 32'd2);
        chk("tmo_busy", {31'h0, busy}, 32'd0);
        chk("tmo_nsnd", 32'(n_snd - snd0), 32'(TMO_ISSUES));
        chk("tmo_q", 32'(exp_q.size()), 32'd0);
        resp_mode = 1;

        // Full / overflow
        do_clear();
        for (int i = 0; i < 5; i++) do_load(16'h1000 + 16'(i));
        chk("full_count", 32'(count), 32'd4);
        chk("full_flag", {31'h0, full}, 32'd1);
        chk("full_ovf", {31'h0, ovf}, 32'd1);
        do_clear();
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_ovf", {31'h0, ovf}, 32'd0);
        chk("clr_full", {31'h0, full}, 32'd0);

        // Abort together with an ACK, then replay
        for (int i = 0; i < 3; i++) do_load(prog[i]);
        exp_q.push_back(prog[0]);
        resp_mode = 2;
        do_start();
        begin
            int n = 0;
            @(negedge clk);
            while (!abort && n < 100) begin @(negedge clk); n++; end
            chk("abort_seen", {31'h0, abort}, 32'd1);
        end
        tick();
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_code", {30'h0, err_code}, 32'd3);
        chk("abort_err", {31'h0, err}, 32'd1);
        chk("abort_idx", 32'(idx), 32'd0);
        resp_mode = 1;
        tick();
        for (int i = 0; i < 3; i++) exp_q.push_back(prog[i]);
        snd0 = n_snd;
        do_start();
        wait_idle();
        chk("replay_done", {31'h0, done}, 32'd1);
        chk("replay_nsnd", 32'(n_snd - snd0), 32'd3);
        chk("replay_code", {30'h0, err_code}, 32'd0);

        // Empty start
        do_clear();
        snd0 = n_snd;
        do_start();
        chk("empty_done", {31'h0, done}, 32'd1);
        chk("empty_busy", {31'h0, busy}, 32'd0);
        repeat (4) tick();
        chk("empty_nsnd", 32'(n_snd - snd0), 32'd0);

        // Reset in WAIT_RESP
        do_load(prog[1]);
        exp_q.push_back(prog[1]);
        resp_mode = 0;
        do_start();
        wait_snd();
        repeat (6) tick();
        chk("pre_rst_busy", {31'h0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        tick();
        chk("rst_q", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
